// File: rtl/vga_vram_scanner.sv
// Purpose : VGA raster controller scanning three 1-bit VRAMs (R/G/B), with each VRAM pixel
//           upscaled SCALE x SCALE on screen, and driving 4-bit-per-colour VGA pins.
// Latency : pixel (h,v) reaches vga_* exactly 2 clks after the counters enter (h,v),
//           with 1 clk for the BRAM read and 1 clk for the output register.
// Backpressure: none. This is a free-running raster that never stalls.
// Ports:
//   clk, reset (async active-low)           clock and reset
//   vram_addr[13:0]                         shared VRAM read address {row[6:0], col[6:0]}
//   vram_red/green/blue                     VRAM data out, valid 1 clk after vram_addr
//   vga_r/g/b[3:0], vga_hsync, vga_vsync    VGA pins (syncs active-low)
//   frame_start                             1-clk pulse when the raster wraps to (0,0)
module vga_vram_scanner #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 5
) (
  input  logic        clk,
  input  logic        reset,
  output logic [13:0] vram_addr,
  input  logic        vram_red,
  input  logic        vram_green,
  input  logic        vram_blue,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(PIX_DIV);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [SW-1:0] SUB_LAST   = SW'(SCALE - 1);

  // Raster state (stage E0)
  logic [DW-1:0] div_q,  div_d;
  logic [HW-1:0] h_q,    h_d;
  logic [VW-1:0] v_q,    v_d;
  logic [SW-1:0] csub_q, csub_d;
  logic [6:0]    col_q,  col_d;
  logic [SW-1:0] rsub_q, rsub_d;
  logic [6:0]    row_q,  row_d;
  logic [13:0]   addr_q, addr_d;
  logic          fs_q,   fs_d;

  // Timing delay stage aligned with the BRAM read (stage E1)
  logic          act1_q, hs1_q, vs1_q;

  // Output registers (stage E2)
  logic [3:0]    r_q, g_q, b_q;
  logic          hsync_q, vsync_q;

  logic pix_tick;
  logic h_wrap, v_wrap;
  logic act_now, hs_now, vs_now;

  assign pix_tick = (div_q == DIV_LAST);
  assign h_wrap   = (h_q == H_LAST);
  assign v_wrap   = (v_q == V_LAST);

  // Classification of the position the counters currently hold; this feeds stage E1.
  assign act_now  = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_now   = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
  assign vs_now   = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));

  always_comb begin
    div_d  = pix_tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    csub_d = csub_q;
    col_d  = col_q;
    rsub_d = rsub_q;
    row_d  = row_q;
    addr_d = addr_q;
    fs_d   = 1'b0;

    if (pix_tick) begin
      h_d  = h_wrap ? '0 : h_q + 1'b1;
      fs_d = h_wrap && v_wrap;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end

      // Column scaler: advance only when moving between two visible pixels
      // of a visible line, so col freezes on the last column through blanking.
      if (h_wrap) begin
        csub_d = '0;
        col_d  = '0;
      end else if ((h_q < H_ACT_LAST) && (v_q < V_ACT)) begin
        if (csub_q == SUB_LAST) begin
          csub_d = '0;
          col_d  = col_q + 7'd1;
        end else begin
          csub_d = csub_q + 1'b1;
        end
      end

      // Row scaler: same scheme, stepped at line ends between visible lines.
      if (h_wrap) begin
        if (v_wrap) begin
          rsub_d = '0;
          row_d  = '0;
        end else if (v_q < V_ACT_LAST) begin
          if (rsub_q == SUB_LAST) begin
            rsub_d = '0;
            row_d  = row_q + 7'd1;
          end else begin
            rsub_d = rsub_q + 1'b1;
          end
        end
      end

      // The address follows the new position only if that position is
      // visible. Otherwise it holds the last visible pixel's address.
      if ((h_d < H_ACT) && (v_d < V_ACT)) begin
        addr_d = {row_d, col_d};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      csub_q  <= '0;
      col_q   <= '0;
      rsub_q  <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      fs_q    <= 1'b0;
      act1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      r_q     <= 4'h0;
      g_q     <= 4'h0;
      b_q     <= 4'h0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      csub_q  <= csub_d;
      col_q   <= col_d;
      rsub_q  <= rsub_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      fs_q    <= fs_d;
      // E1: the BRAM is reading addr_q now, so delay the timing signals one clk to match.
      act1_q  <= act_now;
      hs1_q   <= hs_now;
      vs1_q   <= vs_now;
      // E2: VRAM data belongs to the position captured in stage 1.
      r_q     <= act1_q ? {4{vram_red}}   : 4'h0;
      g_q     <= act1_q ? {4{vram_green}} : 4'h0;
      b_q     <= act1_q ? {4{vram_blue}}  : 4'h0;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
    end
  end

  assign vram_addr   = addr_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_vram_scanner.sv
// Purpose : randomized bench for vga_vram_scanner on a reduced raster, compared against a
//           position-arithmetic reference model.
// Latency : the model predicts vram_addr from the raster position and vga_* from the position
//           2 clks earlier.
// Backpressure: none (free-running DUT).
module tb_vga_vram_scanner;

  localparam int PD  = 4;
  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HS  = 8;
  localparam int HBP = 4;
  localparam int VA  = 30;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int S   = 5;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  logic        clk;
  logic        reset;
  logic [13:0] vram_addr;
  logic        vram_red, vram_green, vram_blue;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, frame_start;

  logic mem_r [0:16383];
  logic mem_g [0:16383];
  logic mem_b [0:16383];

  int vec_cnt = 0;
  int err_cnt = 0;
  int n_clk   = 0;

  vga_vram_scanner #(
    .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SCALE(S)
  ) dut (
    .clk(clk), .reset(reset), .vram_addr(vram_addr),
    .vram_red(vram_red), .vram_green(vram_green), .vram_blue(vram_blue),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM with 1-clk latency
  always @(posedge clk) begin
    vram_red   <= mem_r[vram_addr];
    vram_green <= mem_g[vram_addr];
    vram_blue  <= mem_b[vram_addr];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs != exp) begin
      err_cnt++;
      $display("FAIL %s at clk %0d: got %0h expected %0h", tag, n_clk, obs, exp);
    end
  endtask

  // Raster position m clks after reset release; the first tick is at clk PD.
  function automatic void model_pos(input int m, output int h, output int v);
    int p;
    p = (m / PD) % FT;
    h = p % HT;
    v = p / HT;
  endfunction

  // The address of the current pixel if it is visible, else that of the last visible pixel passed.
  function automatic int model_addr(input int m);
    int h, v, row, col;
    model_pos(m, h, v);
    if (h < HA && v < VA) begin
      row = v / S; col = h / S;
    end else if (v < VA) begin
      row = v / S; col = (HA - 1) / S;
    end else begin
      row = (VA - 1) / S; col = (HA - 1) / S;
    end
    return row * 128 + col;
  endfunction

  task automatic check_reset_vals();
    chk("rst_addr", vram_addr, 0);
    chk("rst_r", vga_r, 0);
    chk("rst_g", vga_g, 0);
    chk("rst_b", vga_b, 0);
    chk("rst_hs", vga_hsync, 1);
    chk("rst_vs", vga_vsync, 1);
    chk("rst_fs", frame_start, 0);
  endtask

  task automatic check_all();
    int h, v, a, m, er, eg, eb, ehs, evs, efs;
    logic act;
    chk("addr", vram_addr, model_addr(n_clk));
    if (n_clk < 2) begin
      er = 0; eg = 0; eb = 0; ehs = 1; evs = 1;
    end else begin
      m = n_clk - 2;
      model_pos(m, h, v);
      act = (h < HA) && (v < VA);
      a   = model_addr(m);
      er  = (act && mem_r[a]) ? 15 : 0;
      eg  = (act && mem_g[a]) ? 15 : 0;
      eb  = (act && mem_b[a]) ? 15 : 0;
      ehs = (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
      evs = (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
    end
    efs = (n_clk > 0 && (n_clk % PD) == 0 && ((n_clk / PD) % FT) == 0) ? 1 : 0;
    chk("vga_r", vga_r, er);
    chk("vga_g", vga_g, eg);
    chk("vga_b", vga_b, eb);
    chk("hsync", vga_hsync, ehs);
    chk("vsync", vga_vsync, evs);
    chk("frame_start", frame_start, efs);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      n_clk++;
      #1;
      check_all();
    end
  endtask

  // Hold reset for a few clocks, load the VRAM contents, then release between clock edges.
  task automatic reset_and_load(input int mode);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_vals();
    for (int i = 0; i < 16384; i++) begin
      case (mode)
        0: begin
          mem_r[i] = 1'($urandom_range(0, 1));
          mem_g[i] = 1'($urandom_range(0, 1));
          mem_b[i] = 1'($urandom_range(0, 1));
        end
        1: begin
          mem_r[i] = 1'b0;
          mem_g[i] = (i == 5);
          mem_b[i] = 1'b0;
        end
        default: begin
          mem_r[i] = 1'b1;
          mem_g[i] = 1'b1;
          mem_b[i] = 1'b1;
        end
      endcase
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_vals();
    end
    #2;
    reset = 1'b1;
    n_clk = 0;
  endtask

  initial begin
    int tgt;
    reset = 1'b0;
    vram_red = 1'b0; vram_green = 1'b0; vram_blue = 1'b0;

    // Random image: cover two full frames so the frame_start period is exercised.
    reset_and_load(0);
    run(2 * FT * PD + 100);

    // A single green VRAM pixel at address 5.
    reset_and_load(1);
    run(FT * PD + 20);

    // An all-ones image, which lights only the visible area.
    reset_and_load(2);
    run(FT * PD + 20);

    // Mid-frame asynchronous reset inside the visible area, after a random image load.
    reset_and_load(0);
    tgt = PD * (HT * $urandom_range(5, 20) + $urandom_range(10, 30)) + $urandom_range(0, PD - 1);
    run(tgt);
    #2;
    reset = 1'b0;
    #1;
    check_reset_vals();
    repeat (3) begin
      @(posedge clk);
      #1;
      check_reset_vals();
    end
    #2;
    reset = 1'b1;
    n_clk = 0;
    run(FT * PD + 200);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
